prf_wr_bank_arbiter: RTL and testbench
======================================

// Module: prf_wr_bank_arbiter
// PURPOSE
// - Shares the banked PRF write ports among all writeback producers (WR_BUF, LDU bank 0/1, ALU reg-reg, MDU, ALU reg-imm, BRU, SYSU).
// - Each producer has a small input FIFO. Each PRF bank accepts one write per cycle.
// - Each cycle, per bank, a round-robin arbiter picks one FIFO head that targets that bank. The winner drives a registered write into that bank.
// - Sits between the execution-unit writeback outputs and the PRF bank write ports.
// PARAMETERS
// - PRF_WR_COUNT       8    number of write requesters
// - PRF_BANK_COUNT     4    number of PRF banks; bank = pr[LOG_PRF_BANK_COUNT-1:0]
// - PR_COUNT           128  physical register count; pr width = $clog2(PR_COUNT) = 7
// - INPUT_BUFFER_SIZE  2    per-requester FIFO depth, >= 1
// - XLEN               64   write data width
// PORTS
// - CLK                     in   1                 core clock
// - nRST                    in   1                 async active-low reset
// - req_valid_by_wr         in   [WR]              requester has a write
// - req_pr_by_wr            in   [WR][7]           destination PR
// - req_data_by_wr          in   [WR][XLEN]        write data
// - req_ready_by_wr         out  [WR]              FIFO can accept this cycle
// - wr_valid_by_bank        out  [BANK]            bank write enable, registered
// - wr_upper_pr_by_bank     out  [BANK][5]         pr[6:2] row within bank
// - wr_data_by_bank         out  [BANK][XLEN]      write data
// - wr_src_by_bank          out  [BANK][3]         winning requester index, for debug and complete tracking
// BEHAVIOUR
// - Reset (async, nRST=0):
//   - All FIFOs empty, all rr_ptr[b]=0.
//   - All wr_* outputs 0.
//   - req_ready = 1 once the FIFOs are empty.
// - Enqueue:
//   - req_ready[i] = (count[i] < INPUT_BUFFER_SIZE). Purely from the current count; no credit is given for a same-cycle dequeue.
//   - When valid&&ready, the entry is written at the tail on the clock edge.
//   - valid while !ready: the producer must hold its payload; nothing is lost or duplicated.
// - FIFO:
//   - Circular head/tail pointers that wrap at INPUT_BUFFER_SIZE-1 -> 0, plus a count.
//   - Only the head is eligible for arbitration.
//   - At most 1 dequeue per FIFO per cycle.
//   - Enqueue and dequeue in the same cycle leave count unchanged.
//   - No bypass: an entry enqueued at edge N is first eligible in cycle N+1.
// - Arbitration (combinational, every cycle, per bank b):
//   - cand[i] = (count[i]!=0) && head_pr[i][1:0]==b.
//   - Grant the first cand scanning i = rr_ptr[b], rr_ptr[b]+1, ... modulo PRF_WR_COUNT.
//   - At most 1 grant per bank. A FIFO head targets exactly one bank, so it can win at most once.
//   - On a grant: dequeue the winner, and rr_ptr[b] <= (winner+1) mod PRF_WR_COUNT (wraps 7->0).
//   - No grant: rr_ptr[b] holds.
// - Output register:
//   - On a grant, wr_valid_by_bank[b] <= 1 and upper_pr/data/src <= the winner's head fields.
//   - Otherwise wr_valid_by_bank[b] <= 0; the other fields may hold.
//   - Latency: accepted at edge N -> arbitrated in cycle N+1 -> write visible cycle N+2 (minimum 2 cycles).
// - Throughput:
//   - Up to PRF_BANK_COUNT writes per cycle when heads target distinct banks.
//   - One write per cycle per bank under conflict.
//   - Fairness: a head competing with k others for one bank is granted within k+1 cycles.
// - Ordering:
//   - Writes from one requester retire in enqueue order, including across banks (head-only).
//   - Head-of-line blocking on a busy bank is accepted.
//   - No ordering is guaranteed between different requesters.
// - PR 0 is not special-cased; it is written like any other PR.
// - Reset mid-operation: FIFO contents are discarded and outputs drop to 0 immediately (async). No write issues from pre-reset entries after release.
// TESTING
// - Reset: hold nRST=0 for 3 cycles, release.
//   -> all req_ready=1, wr_valid=0, rr_ptr=0 until the first request.
// - Single write: cycle 0, req 3 pr=0x15 data=0xDEAD.
//   -> cycle 2: wr_valid[1]=1, upper_pr=5, data=0xDEAD, src=3; banks 0/2/3 invalid.
// - Bank conflict: cycle 0, reqs 0,1,2 all with pr bank 0 (pr 0x04, 0x08, 0x0C).
//   -> bank 0 writes src 0,1,2 in cycles 2,3,4; rr_ptr[0]=3 afterwards.
// - Parallel banks: reqs 1,4,6,7 with pr 0x10,0x21,0x32,0x43.
//   -> cycle 2: all 4 wr_valid=1 with upper_pr 4,8,12,16.
// - Backpressure/fairness: reqs 4 and 5 each stream 4 writes to bank 2 every cycle.
//   -> grants alternate 4,5,4,5...
//   -> req_ready drops to 0 when count=2.
//   -> all 8 writes appear exactly once, per-requester order preserved.
// - Reset mid-flight: fill FIFOs 0..7 with two entries each, then assert nRST for 1 cycle.
//   -> wr_valid=0 immediately, no writes after release, all req_ready=1.

Source files
------------

// File: rtl/prf_wr_bank_arbiter.sv
// prf_wr_bank_arbiter
//
// Shares the banked PRF write ports among all writeback producers. Each producer
// owns a small FIFO. Every cycle, each bank runs an independent round-robin
// arbiter over the FIFO heads that target it, and the winner is written into a
// registered per-bank write port.
//
// Ports
//   CLK                  core clock
//   nRST                 asynchronous active-low reset
//   req_valid_by_wr      producer i has a write this cycle
//   req_pr_by_wr         destination physical register per producer
//   req_data_by_wr       write data per producer
//   req_ready_by_wr      producer FIFO has room (based on current count only)
//   wr_valid_by_bank     registered bank write enable
//   wr_upper_pr_by_bank  row within the bank (pr without the bank-select bits)
//   wr_data_by_bank      registered write data
//   wr_src_by_bank       index of the producer that won the bank
//
// Latency: a write accepted at edge N is arbitrated in cycle N+1 and is visible
// on the bank port in cycle N+2. There is no FIFO bypass.

module prf_wr_bank_arbiter #(
    parameter int unsigned PRF_WR_COUNT       = 8,
    parameter int unsigned PRF_BANK_COUNT     = 4,
    parameter int unsigned PR_COUNT           = 128,
    parameter int unsigned INPUT_BUFFER_SIZE  = 2,
    parameter int unsigned XLEN               = 64,
    localparam int unsigned LOG_PR_COUNT       = $clog2(PR_COUNT),
    localparam int unsigned LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT),
    localparam int unsigned UPPER_PR_W         = LOG_PR_COUNT - LOG_PRF_BANK_COUNT,
    localparam int unsigned SRC_W              = $clog2(PRF_WR_COUNT)
) (
    input  logic                                       CLK,
    input  logic                                       nRST,
    input  logic [PRF_WR_COUNT-1:0]                    req_valid_by_wr,
    input  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]  req_pr_by_wr,
    input  logic [PRF_WR_COUNT-1:0][XLEN-1:0]          req_data_by_wr,
    output logic [PRF_WR_COUNT-1:0]                    req_ready_by_wr,
    output logic [PRF_BANK_COUNT-1:0]                  wr_valid_by_bank,
    output logic [PRF_BANK_COUNT-1:0][UPPER_PR_W-1:0]  wr_upper_pr_by_bank,
    output logic [PRF_BANK_COUNT-1:0][XLEN-1:0]        wr_data_by_bank,
    output logic [PRF_BANK_COUNT-1:0][SRC_W-1:0]       wr_src_by_bank
);

    // A depth-1 FIFO still gets a 1-bit pointer; it simply never leaves 0.
    localparam int unsigned PTR_W = (INPUT_BUFFER_SIZE > 1) ? $clog2(INPUT_BUFFER_SIZE) : 1;
    localparam int unsigned CNT_W = $clog2(INPUT_BUFFER_SIZE + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(INPUT_BUFFER_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(INPUT_BUFFER_SIZE);
    localparam logic [SRC_W-1:0] SRC_LAST = SRC_W'(PRF_WR_COUNT - 1);

    // ------------------------------------------------------------------
    // Producer FIFOs
    // ------------------------------------------------------------------
    logic [LOG_PR_COUNT-1:0] fifo_pr_q   [PRF_WR_COUNT][INPUT_BUFFER_SIZE];
    logic [XLEN-1:0]         fifo_data_q [PRF_WR_COUNT][INPUT_BUFFER_SIZE];

    logic [PRF_WR_COUNT-1:0][PTR_W-1:0]        head_q, head_d;
    logic [PRF_WR_COUNT-1:0][PTR_W-1:0]        tail_q, tail_d;
    logic [PRF_WR_COUNT-1:0][CNT_W-1:0]        count_q, count_d;
    logic [PRF_WR_COUNT-1:0]                   enq;
    logic [PRF_WR_COUNT-1:0]                   deq;
    logic [PRF_WR_COUNT-1:0]                   nonempty;
    logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0] head_pr;
    logic [PRF_WR_COUNT-1:0][XLEN-1:0]         head_data;

    // ------------------------------------------------------------------
    // Arbitration state
    // ------------------------------------------------------------------
    logic [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0] cand;
    logic [PRF_BANK_COUNT-1:0]                   grant_valid;
    logic [PRF_BANK_COUNT-1:0][SRC_W-1:0]        grant_idx;
    logic [PRF_BANK_COUNT-1:0][SRC_W-1:0]        rr_ptr_q, rr_ptr_d;

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [PRF_BANK_COUNT-1:0]                  wr_valid_q;
    logic [PRF_BANK_COUNT-1:0][UPPER_PR_W-1:0]  wr_upper_pr_q;
    logic [PRF_BANK_COUNT-1:0][XLEN-1:0]        wr_data_q;
    logic [PRF_BANK_COUNT-1:0][SRC_W-1:0]       wr_src_q;

    // Ready depends only on the registered count: a dequeue in the same cycle
    // does not free a slot early, which keeps ready off the arbiter path.
    always_comb begin
        for (int i = 0; i < PRF_WR_COUNT; i++) begin
            req_ready_by_wr[i] = (count_q[i] < CNT_FULL);
            nonempty[i]        = (count_q[i] != '0);
        end
    end

    assign enq = req_valid_by_wr & req_ready_by_wr;

    always_comb begin
        for (int i = 0; i < PRF_WR_COUNT; i++) begin
            head_pr[i]   = fifo_pr_q[i][head_q[i]];
            head_data[i] = fifo_data_q[i][head_q[i]];
        end
    end

    // Only FIFO heads compete; the low pr bits select the bank.
    always_comb begin
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                cand[b][i] = nonempty[i] &&
                             (head_pr[i][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b));
            end
        end
    end

    // Round-robin pick per bank. The scan runs from the farthest offset back
    // to offset 0 so the candidate nearest rr_ptr is the last (winning) write.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_valid = '0;
        grant_idx   = '0;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            for (int k = PRF_WR_COUNT - 1; k >= 0; k--) begin
                idx = (32'(rr_ptr_q[b]) + 32'(k)) % PRF_WR_COUNT;
                if (cand[b][idx]) begin
                    grant_valid[b] = 1'b1;
                    grant_idx[b]   = SRC_W'(idx);
                end
            end
        end
    end

    // A head targets exactly one bank, so at most one grant lands on a FIFO.
    always_comb begin
        deq      = '0;
        rr_ptr_d = rr_ptr_q;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            if (grant_valid[b]) begin
                deq[grant_idx[b]] = 1'b1;
                rr_ptr_d[b]       = (grant_idx[b] == SRC_LAST) ? '0
                                                                : grant_idx[b] + SRC_W'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < PRF_WR_COUNT; i++) begin
            head_d[i]  = head_q[i];
            tail_d[i]  = tail_q[i];
            count_d[i] = count_q[i];
            if (enq[i]) begin
                tail_d[i] = (tail_q[i] == PTR_LAST) ? '0 : tail_q[i] + PTR_W'(1);
            end
            if (deq[i]) begin
                head_d[i] = (head_q[i] == PTR_LAST) ? '0 : head_q[i] + PTR_W'(1);
            end
            if (enq[i] && !deq[i]) begin
                count_d[i] = count_q[i] + CNT_W'(1);
            end else if (!enq[i] && deq[i]) begin
                count_d[i] = count_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by count_q alone,
    // so stale entries are never seen after reset.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < PRF_WR_COUNT; i++) begin
            if (enq[i]) begin
                fifo_pr_q[i][tail_q[i]]   <= req_pr_by_wr[i];
                fifo_data_q[i][tail_q[i]] <= req_data_by_wr[i];
            end
        end
    end

    // Non-valid cycles keep the last payload to avoid needless toggling.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_valid_q    <= '0;
            wr_upper_pr_q <= '0;
            wr_data_q     <= '0;
            wr_src_q      <= '0;
        end else begin
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                wr_valid_q[b] <= grant_valid[b];
                if (grant_valid[b]) begin
                    wr_upper_pr_q[b] <=
                        head_pr[grant_idx[b]][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
                    wr_data_q[b]     <= head_data[grant_idx[b]];
                    wr_src_q[b]      <= grant_idx[b];
                end
            end
        end
    end

    assign wr_valid_by_bank    = wr_valid_q;
    assign wr_upper_pr_by_bank = wr_upper_pr_q;
    assign wr_data_by_bank     = wr_data_q;
    assign wr_src_by_bank      = wr_src_q;

endmodule

// File: tb/tb_prf_wr_bank_arbiter.sv
// Testbench for prf_wr_bank_arbiter: table of single-cycle, conflict-free
// transactions plus hand-written sequences for bank conflict, round-robin
// pointer state, backpressure/fairness and mid-flight reset.

module tb_prf_wr_bank_arbiter;

    logic                   CLK = 1'b0;
    logic                   nRST;
    logic [7:0]             req_valid;
    logic [7:0][6:0]        req_pr;
    logic [7:0][63:0]       req_data;
    logic [7:0]             req_ready;
    logic [3:0]             wr_valid;
    logic [3:0][4:0]        wr_upper;
    logic [3:0][63:0]       wr_data;
    logic [3:0][2:0]        wr_src;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    prf_wr_bank_arbiter dut (
        .CLK                 (CLK),
        .nRST                (nRST),
        .req_valid_by_wr     (req_valid),
        .req_pr_by_wr        (req_pr),
        .req_data_by_wr      (req_data),
        .req_ready_by_wr     (req_ready),
        .wr_valid_by_bank    (wr_valid),
        .wr_upper_pr_by_bank (wr_upper),
        .wr_data_by_bank     (wr_data),
        .wr_src_by_bank      (wr_src)
    );

    typedef struct {
        string            name;
        logic [7:0]       valid;
        logic [7:0][6:0]  pr;
        logic [7:0][63:0] data;
        logic [3:0]       exp_valid;
        logic [3:0][4:0]  exp_upper;
        logic [3:0][63:0] exp_data;
        logic [3:0][2:0]  exp_src;
    } vec_t;

    localparam int NVEC = 5;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_req();
        req_valid = '0;
        req_pr    = '0;
        req_data  = '0;
    endtask

    task automatic set_req(input int v, input int r, input logic [6:0] pr,
                           input logic [63:0] d);
        vecs[v].valid[r] = 1'b1;
        vecs[v].pr[r]    = pr;
        vecs[v].data[r]  = d;
    endtask

    task automatic set_exp(input int v, input int b, input logic [4:0] up,
                           input logic [63:0] d, input logic [2:0] src);
        vecs[v].exp_valid[b] = 1'b1;
        vecs[v].exp_upper[b] = up;
        vecs[v].exp_data[b]  = d;
        vecs[v].exp_src[b]   = src;
    endtask

    task automatic fill_vectors();
        for (int v = 0; v < NVEC; v++) begin
            vecs[v].valid     = '0;
            vecs[v].pr        = '0;
            vecs[v].data      = '0;
            vecs[v].exp_valid = '0;
            vecs[v].exp_upper = '0;
            vecs[v].exp_data  = '0;
            vecs[v].exp_src   = '0;
        end
        vecs[0].name = "single";
        set_req(0, 3, 7'h15, 64'hDEAD);
        set_exp(0, 1, 5'd5, 64'hDEAD, 3'd3);

        vecs[1].name = "parallel";
        set_req(1, 1, 7'h10, 64'h1111);
        set_req(1, 4, 7'h21, 64'h4444);
        set_req(1, 6, 7'h32, 64'h6666);
        set_req(1, 7, 7'h43, 64'h7777);
        set_exp(1, 0, 5'd4,  64'h1111, 3'd1);
        set_exp(1, 1, 5'd8,  64'h4444, 3'd4);
        set_exp(1, 2, 5'd12, 64'h6666, 3'd6);
        set_exp(1, 3, 5'd16, 64'h7777, 3'd7);

        vecs[2].name = "pr_zero";
        set_req(2, 0, 7'h00, 64'hA5A5);
        set_exp(2, 0, 5'd0, 64'hA5A5, 3'd0);

        vecs[3].name = "pr_max";
        set_req(3, 7, 7'h7F, 64'hFFFF_FFFF_FFFF_FFFF);
        set_req(3, 2, 7'h7C, 64'h0123_4567_89AB_CDEF);
        set_exp(3, 3, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 3'd7);
        set_exp(3, 0, 5'd31, 64'h0123_4567_89AB_CDEF, 3'd2);

        vecs[4].name = "two_banks";
        set_req(4, 5, 7'h41, 64'h55);
        set_req(4, 0, 7'h02, 64'h1);
        set_exp(4, 1, 5'd16, 64'h55, 3'd5);
        set_exp(4, 2, 5'd0,  64'h1,  3'd0);
    endtask

    task automatic chk_bank(input string name, input int b, input logic [4:0] up,
                            input logic [63:0] d, input logic [2:0] src);
        chk({name, "_upper"}, 64'(wr_upper[b]), 64'(up));
        chk({name, "_data"},  wr_data[b],       d);
        chk({name, "_src"},   64'(wr_src[b]),   64'(src));
    endtask

    int               n4, n5;
    bit               saw_nr4, saw_nr5;
    logic [7:0]       rdy;
    int               log_src [$];
    int               log_up  [$];
    logic [63:0]      log_dat [$];

    initial begin
        fill_vectors();
        clear_req();

        // ---------------- reset ----------------
        nRST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_hold_valid", 64'(wr_valid), 64'h0);
        chk("rst_hold_ready", 64'(req_ready), 64'hFF);
        @(negedge CLK) nRST = 1'b1;
        step();
        chk("rst_valid", 64'(wr_valid), 64'h0);
        chk("rst_ready", 64'(req_ready), 64'hFF);
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("rst_b%0d", b), 64'(wr_upper[b]), 64'h0);
            chk($sformatf("rst_data_b%0d", b), wr_data[b], 64'h0);
            chk($sformatf("rst_src_b%0d", b), 64'(wr_src[b]), 64'h0);
        end

        // ---------------- bank conflict from rr_ptr = 0 ----------------
        req_valid[0] = 1'b1; req_pr[0] = 7'h04; req_data[0] = 64'h100;
        req_valid[1] = 1'b1; req_pr[1] = 7'h08; req_data[1] = 64'h101;
        req_valid[2] = 1'b1; req_pr[2] = 7'h0C; req_data[2] = 64'h102;
        step();
        clear_req();
        chk("confl_c1_valid", 64'(wr_valid), 64'h0);
        step();
        chk("confl_c2_valid", 64'(wr_valid), 64'h1);
        chk_bank("confl_c2", 0, 5'd1, 64'h100, 3'd0);
        step();
        chk("confl_c3_valid", 64'(wr_valid), 64'h1);
        chk_bank("confl_c3", 0, 5'd2, 64'h101, 3'd1);
        step();
        chk("confl_c4_valid", 64'(wr_valid), 64'h1);
        chk_bank("confl_c4", 0, 5'd3, 64'h102, 3'd2);
        step();
        chk("confl_c5_valid", 64'(wr_valid), 64'h0);
        step();

        // rr_ptr[0] is now 3, so requester 3 must beat requester 0.
        req_valid[0] = 1'b1; req_pr[0] = 7'h00; req_data[0] = 64'h200;
        req_valid[3] = 1'b1; req_pr[3] = 7'h04; req_data[3] = 64'h203;
        step();
        clear_req();
        step();
        chk("rr_c2_valid", 64'(wr_valid), 64'h1);
        chk_bank("rr_c2", 0, 5'd1, 64'h203, 3'd3);
        step();
        chk("rr_c3_valid", 64'(wr_valid), 64'h1);
        chk_bank("rr_c3", 0, 5'd0, 64'h200, 3'd0);
        step();
        chk("rr_c4_valid", 64'(wr_valid), 64'h0);
        step();

        // ---------------- table-driven single transactions ----------------
        for (int v = 0; v < NVEC; v++) begin
            req_valid = vecs[v].valid;
            req_pr    = vecs[v].pr;
            req_data  = vecs[v].data;
            step();
            clear_req();
            step();
            for (int b = 0; b < 4; b++) begin
                chk($sformatf("%s_valid_b%0d", vecs[v].name, b),
                    64'(wr_valid[b]), 64'(vecs[v].exp_valid[b]));
                if (vecs[v].exp_valid[b]) begin
                    chk_bank($sformatf("%s_b%0d", vecs[v].name, b), b,
                             vecs[v].exp_upper[b], vecs[v].exp_data[b], vecs[v].exp_src[b]);
                end
            end
            step();
            chk({vecs[v].name, "_idle"}, 64'(wr_valid), 64'h0);
            step();
        end

        // ---------------- backpressure / fairness on bank 2 ----------------
        n4 = 0; n5 = 0; saw_nr4 = 1'b0; saw_nr5 = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            clear_req();
            if (n4 < 4) begin
                req_valid[4] = 1'b1;
                req_pr[4]    = 7'((n4 << 2) | 2);
                req_data[4]  = 64'hF000 + 64'(n4);
            end
            if (n5 < 4) begin
                req_valid[5] = 1'b1;
                req_pr[5]    = 7'(((4 + n5) << 2) | 2);
                req_data[5]  = 64'hF000 + 64'(4 + n5);
            end
            @(negedge CLK);
            rdy = req_ready;
            if (!rdy[4]) saw_nr4 = 1'b1;
            if (!rdy[5]) saw_nr5 = 1'b1;
            step();
            if (req_valid[4] && rdy[4]) n4++;
            if (req_valid[5] && rdy[5]) n5++;
            if (wr_valid[2]) begin
                log_src.push_back(int'(wr_src[2]));
                log_up.push_back(int'(wr_upper[2]));
                log_dat.push_back(wr_data[2]);
            end
        end
        clear_req();
        chk("fair_accepted4", 64'(n4), 64'd4);
        chk("fair_accepted5", 64'(n5), 64'd4);
        chk("fair_notready4", 64'(saw_nr4), 64'd1);
        chk("fair_notready5", 64'(saw_nr5), 64'd1);
        chk("fair_writes", 64'(log_src.size()), 64'd8);
        for (int k = 0; k < 8 && k < log_src.size(); k++) begin
            chk($sformatf("fair_src_%0d", k), 64'(log_src[k]), (k % 2 == 0) ? 64'd4 : 64'd5);
            chk($sformatf("fair_up_%0d", k), 64'(log_up[k]),
                (k % 2 == 0) ? 64'(k / 2) : 64'(4 + k / 2));
            chk($sformatf("fair_data_%0d", k), log_dat[k],
                (k % 2 == 0) ? 64'hF000 + 64'(k / 2) : 64'hF000 + 64'(4 + k / 2));
        end
        chk("fair_ready_after", 64'(req_ready), 64'hFF);

        // ---------------- reset mid-flight ----------------
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 8; i++) begin
                req_valid[i] = 1'b1;
                req_pr[i]    = 7'(i * 4 + i % 4 + c * 64);
                req_data[i]  = 64'(i + 16 * c);
            end
            step();
        end
        clear_req();
        chk("mid_pre_valid", 64'(wr_valid), 64'hF);
        #3 nRST = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(wr_valid), 64'h0);
        chk("mid_rst_ready", 64'(req_ready), 64'hFF);
        @(posedge CLK);
        @(negedge CLK) nRST = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("mid_post_valid_%0d", c), 64'(wr_valid), 64'h0);
        end
        chk("mid_post_ready", 64'(req_ready), 64'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
